// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage. Turns the EXE/MEM memory operation into a
// single-outstanding req/ack bus transaction with store lane steering and
// load extraction/extension, stalling the pipeline until the access completes.
// Optional feature macro: MEM_MISALIGN_EXC_EN (misaligned-access exceptions).
module mem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_op_i,
    input  logic [31:0]           exception_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic [3:0]            bus_be_o,
    input  logic                  bus_ack_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  stall_req_o,
    output logic [31:0]           exception_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t                  state;
    logic [3:0]              op_q;
    logic [1:0]              off_q;
    logic [DATA_WIDTH-1:0]   ld_q;
    logic                    is_mem_code;
    logic                    is_store_code;
    logic                    misalign;
    logic                    mem_op;
    logic                    unused_we;

    // The store flag duplicates information carried by the op code.
    assign unused_we = mem_we_i;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    // Extract the addressed byte/half from the read word and extend it.
    function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [3:0] op,
                                                       input logic [1:0] off,
                                                       input logic [DATA_WIDTH-1:0] w);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [31:0] sx;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   begin sx = $signed(b); fmt_load = sx; end
            OP_LH:   begin sx = $signed(h); fmt_load = sx; end
            OP_LBU:  fmt_load = {24'h0, b};
            OP_LHU:  fmt_load = {16'h0, h};
            default: fmt_load = w;
        endcase
    endfunction

    // Byte enables for the access; loads always read the full word.
    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   store_be = 4'b0001 << off;
            OP_SH:   store_be = 4'b0011 << {off[1], 1'b0};
            default: store_be = 4'hF;
        endcase
    endfunction

    // Replicate store data across lanes so the enabled lanes carry it.
    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [3:0] op,
                                                         input logic [DATA_WIDTH-1:0] d);
        case (op)
            OP_SB:   store_data = {4{d[7:0]}};
            OP_SH:   store_data = {2{d[15:0]}};
            OP_SW:   store_data = d;
            default: store_data = '0;
        endcase
    endfunction

    assign is_mem_code   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
    assign is_store_code = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);

`ifdef MEM_MISALIGN_EXC_EN
    // Flag halfword accesses on odd addresses and word accesses off a word boundary.
    always_comb begin
        misalign = 1'b0;
        if (exception_i == 32'd0) begin
            case (mem_op_i)
                OP_LH, OP_LHU, OP_SH: misalign = mem_addr_i[0];
                OP_LW, OP_SW:         misalign = (mem_addr_i[1:0] != 2'b00);
                default:              misalign = 1'b0;
            endcase
        end
    end

    assign exception_o = (exception_i != 32'd0) ? exception_i :
                         misalign ? (is_store_code ? 32'd6 : 32'd4) : 32'd0;
`else
    assign misalign    = 1'b0;
    assign exception_o = exception_i;
`endif

    assign mem_op = is_mem_code && (exception_i == 32'd0) && !misalign;

    // Hold the pipeline while an access is being launched or is outstanding.
    always_comb begin
        case (state)
            ST_IDLE: stall_req_o = mem_op;
            ST_WAIT: stall_req_o = 1'b1;
            default: stall_req_o = 1'b0;
        endcase
    end

    assign reg_waddr_o = reg_waddr_i;
    assign reg_we_o    = reg_we_i & ~stall_req_o & (exception_i == 32'd0) & ~misalign;
    assign reg_wdata_o = ((state == ST_DONE) && op_is_load(op_q)) ? ld_q : reg_wdata_i;

    // Bus transaction FSM with registered bus outputs and captured load data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_be_o    <= 4'h0;
            ld_q        <= '0;
            op_q        <= 4'd0;
            off_q       <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_store_code;
                        bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        bus_be_o    <= store_be(mem_op_i, mem_addr_i[1:0]);
                        bus_wdata_o <= store_data(mem_op_i, mem_data_i);
                        op_q        <= mem_op_i;
                        off_q       <= mem_addr_i[1:0];
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack_i) begin
                        ld_q      <= fmt_load(op_q, off_q, bus_rdata_i);
                        bus_req_o <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the core, sitting directly downstream of the EXE/MEM pipeline register and upstream of MEM/WB. It turns the registered `mem_op`/`mem_addr`/`mem_data` into a single-outstanding request/acknowledge data-bus transaction. It applies byte-lane steering for stores and extraction with sign/zero extension for loads. It holds the pipeline through `stall_req_o` until the access completes, then presents write-back data to MEM/WB.

## Interface
- `ADDR_WIDTH`, default 32: address width (`ADDR_WIDTH`).
- `DATA_WIDTH`, default 32: data width (`DATA_WIDTH`); the block supports only 32.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `reg_waddr_i` / `reg_we_i` / `reg_wdata_i`  in  5/1/32  write-back request from EXE/MEM.
- `mem_addr_i` / `mem_data_i`  in  32/32  byte address and store data.
- `mem_we_i`  in  1  store flag; informational only, `mem_op_i` is authoritative.
- `mem_op_i`  in  4  operation code: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9–15 are treated as NOP.
- `exception_i`  in  32  exception cause from upstream; 0 means none.
- `bus_req_o`  out  1  request valid.
- `bus_we_o`  out  1  write.
- `bus_addr_o`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wdata_o`  out  32  store data, lane-replicated.
- `bus_be_o`  out  4  byte enables.
- `bus_ack_i`  in  1  transaction complete; read data valid on the same cycle.
- `bus_rdata_i`  in  32  read word.
- `reg_waddr_o` / `reg_we_o` / `reg_wdata_o`  out  5/1/32  to MEM/WB.
- `stall_req_o`  out  1  freeze request to the stall controller.
- `exception_o`  out  32  exception cause to the interrupt controller.

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- A memory op is defined as `mem_op_i` in 1..8 with `exception_i==0` and no misalignment fault.
- **IDLE**
  - With a memory op present, `stall_req_o=1` combinationally.
  - At the clock edge the block latches address, we, be, wdata and op into the bus registers, sets `bus_req_o=1` and moves to WAIT.
  - With anything else present: stall 0, no transaction.
- **WAIT**
  - `stall_req_o=1`.
  - `bus_req_o` and all bus outputs are held stable until `bus_ack_i` is sampled high.
  - On ack, the block latches the formatted load data into `ld_q`, clears `bus_req_o`, and moves to DONE.
- **DONE**
  - `stall_req_o=0` for exactly one cycle, then the FSM moves to IDLE unconditionally.
  - The instruction still on the inputs is never relaunched.
- **Store formatting**
  - SB: `be = 4'b0001<<addr[1:0]`, wdata = byte ×4.
  - SH: `be = 4'b0011<<{addr[1],1'b0}`, wdata = half ×2.
  - SW: `be = 4'hF`.
  - Loads drive `be = 4'hF` and `we = 0`.
- **Load formatting**
  - The block selects the byte at `addr[1:0]` or the half at `addr[1]`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- **Write-back**
  - `reg_waddr_o = reg_waddr_i`.
  - `reg_we_o = reg_we_i & ~stall_req_o`.
  - `reg_wdata_o = ld_q` in DONE for a load, otherwise `reg_wdata_i`.
- **Upstream exception**
  - When `exception_i != 0`, no bus access occurs.
  - `exception_o = exception_i`, `reg_we_o = 0`, stall 0.
- **Ack outside WAIT** is ignored.

## Timing
- **Reset values:** state IDLE; `bus_req_o`, `bus_we_o` = 0; `bus_addr_o`, `bus_wdata_o`, `ld_q` = 0; `bus_be_o = 4'h0`.
- With a NOP input after reset, the combinational outputs are: `stall_req_o=0`, `exception_o=0`, `reg_we_o=reg_we_i`.
- **Minimum latency:**
  - Cycle 0: IDLE with stall.
  - Cycle 1: WAIT with request; ack arrives.
  - Cycle 2: DONE, data valid, stall low.
  - This gives 2 stall cycles; each extra ack-wait cycle adds 1.
- **Reset mid-transaction:** `bus_req_o` drops at the reset edge and the FSM returns to IDLE. A late ack is then ignored.
- **Back-to-back memory ops:** the second op is seen in IDLE on the cycle after DONE.

## Configuration
- Macro: `MEM_MISALIGN_EXC_EN`.
- **Defined:**
  - Misaligned accesses are LH/LHU/SH with `addr[0]=1`, and LW/SW with `addr[1:0]!=0`.
  - A misaligned access produces no transaction, stall 0 and `reg_we_o=0`.
  - `exception_o` = 32'd4 for a load, 32'd6 for a store, combinationally in that cycle.
- **Undefined:**
  - There is no misalignment check and `exception_o = exception_i` always.
  - Halfword accesses use only `addr[1]`; word accesses ignore `addr[1:0]`.

## Test plan
- LW at 0x100, ack on the first WAIT cycle, rdata 0xDEADBEEF -> `bus_addr_o=0x100`, `be=F`, stall high for 2 cycles, DONE `reg_wdata_o=0xDEADBEEF`.
- LB at 0x203, rdata 0x80FFFFFF -> `reg_wdata_o=0xFFFFFF80`; LBU at the same address -> `0x00000080`.
- SH at 0x102, data 0x1234ABCD, ack delayed 3 cycles -> `bus_addr_o=0x100`, `be=1100`, `wdata=0xABCDABCD` held stable, 5 stall cycles total.
- Reset asserted in WAIT, ack arrives the next cycle -> `bus_req_o=0`, IDLE, `stall_req_o=0`, ack ignored.
- LW at 0x102 -> with `MEM_MISALIGN_EXC_EN`: no request, `exception_o=4`, `reg_we_o=0`; without: word 0x100 read normally.
- `exception_i=2` with SW -> no request, `exception_o=2`, `reg_we_o=0`, stall 0.
